// File: rtl/lapido_defs_pkg.sv
// Shared execute-stage definitions: opcodes, flag bit positions, destination
// select encodings and the EX FSM state type.
package lapido_defs;

    localparam int unsigned FUNCT_W = 6;

    localparam logic [FUNCT_W-1:0] OP_SLL = 6'h00;
    localparam logic [FUNCT_W-1:0] OP_SRL = 6'h02;
    localparam logic [FUNCT_W-1:0] OP_MUL = 6'h18;
    localparam logic [FUNCT_W-1:0] OP_ADD = 6'h20;
    localparam logic [FUNCT_W-1:0] OP_SUB = 6'h22;
    localparam logic [FUNCT_W-1:0] OP_AND = 6'h24;
    localparam logic [FUNCT_W-1:0] OP_OR  = 6'h25;
    localparam logic [FUNCT_W-1:0] OP_XOR = 6'h26;
    localparam logic [FUNCT_W-1:0] OP_SLT = 6'h2A;

    localparam int unsigned FLAG_W    = 2;
    localparam int unsigned FLAG_ZERO = 0;
    localparam int unsigned FLAG_NEG  = 1;

    localparam logic [1:0] DEST_RT   = 2'd0;
    localparam logic [1:0] DEST_RD   = 2'd1;
    localparam logic [1:0] DEST_LINK = 2'd2;
    localparam logic [1:0] DEST_RSV  = 2'd3;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } ex_state_e;

endpackage

// File: rtl/ex_pipe_mul_iter.sv
// Iterative shift-add multiplier. Bit 0 is folded in at start so the full
// product is ready in busy cycle DATA_W-1; the unit stays busy DATA_W cycles.
module mul_iter #(
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              abort,
    input  logic              start,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic              done_c,
    output logic              last_c,
    output logic [DATA_W-1:0] product_c
);

    localparam int unsigned CNT_W = $clog2(DATA_W + 1);

    logic              busy;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] acc;
    logic [DATA_W-1:0] mcand;
    logic [DATA_W-1:0] mplier;
    logic [DATA_W-1:0] term;

    assign term      = mplier[0] ? mcand : '0;
    assign product_c = acc + term;
    assign done_c    = busy && (cnt == CNT_W'(DATA_W - 1));
    assign last_c    = busy && (cnt == CNT_W'(DATA_W));

    // cnt equals the index of the multiplier bit being added this cycle
    always_ff @(posedge clk) begin
        if (!rst) begin
            busy   <= 1'b0;
            cnt    <= '0;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
        end else if (abort) begin
            busy <= 1'b0;
            cnt  <= '0;
        end else if (start) begin
            busy   <= 1'b1;
            cnt    <= CNT_W'(1);
            acc    <= b[0] ? a : '0;
            mcand  <= a << 1;
            mplier <= b >> 1;
        end else if (busy) begin
            acc    <= product_c;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            if (last_c) begin
                busy <= 1'b0;
                cnt  <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/ex_pipe.sv
// Execute stage: single-cycle ALU, destination mux and branch-target adder,
// with an iterative multiplier and a valid/ready output register.
module ex_pipe
    import lapido_defs::*;
#(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned PC_W     = 32,
    parameter int unsigned LINK_REG = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [5:0]        alu_funct,
    input  logic              alu_src,
    input  logic [1:0]        sel_reg_dest,
    input  logic              sel_fl_write_enable,
    input  logic [ADDR_W-1:0] address_rt,
    input  logic [ADDR_W-1:0] address_rd,
    input  logic [DATA_W-1:0] data_rs,
    input  logic [DATA_W-1:0] data_rt,
    input  logic [DATA_W-1:0] imm,
    input  logic [PC_W-1:0]   next_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_alu_data,
    output logic [1:0]        out_alu_flags,
    output logic              out_fl_we,
    output logic [ADDR_W-1:0] out_dest,
    output logic [PC_W-1:0]   out_add,
    output logic [DATA_W-1:0] out_data_rt
);

    localparam int unsigned SH_W  = $clog2(DATA_W);
    localparam int unsigned SUM_W = (PC_W > DATA_W) ? PC_W : DATA_W;

    ex_state_e         state;
    logic [DATA_W-1:0] op2;
    logic [SH_W-1:0]   shamt;
    logic [DATA_W-1:0] alu_res_c;
    logic [DATA_W-1:0] mul_prod_c;
    logic              mul_done_c;
    logic              mul_last_c;
    logic              accept;
    logic              start_mul;
    logic [ADDR_W-1:0] dest_c;
    logic [SUM_W-1:0]  target_c;

    function automatic logic [FLAG_W-1:0] flags_of(input logic [DATA_W-1:0] r);
        logic [FLAG_W-1:0] f;
        f            = '0;
        f[FLAG_ZERO] = (r == '0);
        f[FLAG_NEG]  = r[DATA_W-1];
        return f;
    endfunction

    // in_ready is forced low while reset is held so every output reads 0
    assign in_ready  = rst && !flush && (state == ST_IDLE) && (!out_valid || out_ready);
    assign accept    = in_valid && in_ready;
    assign start_mul = accept && (alu_funct == OP_MUL);

    assign op2      = alu_src ? imm : data_rt;
    assign shamt    = op2[SH_W-1:0];
    assign target_c = SUM_W'(next_pc) + SUM_W'($signed(imm));

    always_comb begin
        alu_res_c = '0;
        case (alu_funct)
            OP_ADD:  alu_res_c = data_rs + op2;
            OP_SUB:  alu_res_c = data_rs - op2;
            OP_AND:  alu_res_c = data_rs & op2;
            OP_OR:   alu_res_c = data_rs | op2;
            OP_XOR:  alu_res_c = data_rs ^ op2;
            OP_SLT:  alu_res_c = DATA_W'($signed(data_rs) < $signed(op2));
            OP_SLL:  alu_res_c = data_rs << shamt;
            OP_SRL:  alu_res_c = data_rs >> shamt;
            default: alu_res_c = '0;
        endcase
    end

    always_comb begin
        dest_c = address_rt;
        case (sel_reg_dest)
            DEST_RD:   dest_c = address_rd;
            DEST_LINK: dest_c = ADDR_W'(LINK_REG);
            DEST_RT,
            DEST_RSV:  dest_c = address_rt;
            default:   dest_c = address_rt;
        endcase
    end

    mul_iter #(
        .DATA_W(DATA_W)
    ) u_mul (
        .clk       (clk),
        .rst       (rst),
        .abort     (flush),
        .start     (start_mul),
        .a         (data_rs),
        .b         (op2),
        .done_c    (mul_done_c),
        .last_c    (mul_last_c),
        .product_c (mul_prod_c)
    );

    // Side fields load at acceptance; a MUL leaves out_valid low until done
    always_ff @(posedge clk) begin
        if (!rst) begin
            state         <= ST_IDLE;
            out_valid     <= 1'b0;
            out_alu_data  <= '0;
            out_alu_flags <= '0;
            out_fl_we     <= 1'b0;
            out_dest      <= '0;
            out_add       <= '0;
            out_data_rt   <= '0;
        end else if (flush) begin
            state     <= ST_IDLE;
            out_valid <= 1'b0;
        end else begin
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        out_fl_we   <= sel_fl_write_enable;
                        out_dest    <= dest_c;
                        out_add     <= target_c[PC_W-1:0];
                        out_data_rt <= data_rt;
                        if (start_mul) begin
                            state     <= ST_MUL;
                            out_valid <= 1'b0;
                        end else begin
                            out_valid     <= 1'b1;
                            out_alu_data  <= alu_res_c;
                            out_alu_flags <= flags_of(alu_res_c);
                        end
                    end
                end
                ST_MUL: begin
                    if (mul_done_c) begin
                        out_valid     <= 1'b1;
                        out_alu_data  <= mul_prod_c;
                        out_alu_flags <= flags_of(mul_prod_c);
                    end
                    if (mul_last_c) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ex_pipe.sv
// Testbench for ex_pipe: directed scenarios plus a randomized scoreboard run
// against an arithmetic reference model.
module tb_ex_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [5:0]  alu_funct;
    logic        alu_src;
    logic [1:0]  sel_reg_dest;
    logic        sel_fl_write_enable;
    logic [4:0]  address_rt;
    logic [4:0]  address_rd;
    logic [31:0] data_rs;
    logic [31:0] data_rt;
    logic [31:0] imm;
    logic [31:0] next_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_alu_data;
    logic [1:0]  out_alu_flags;
    logic        out_fl_we;
    logic [4:0]  out_dest;
    logic [31:0] out_add;
    logic [31:0] out_data_rt;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  flags;
        logic        fwe;
        logic [4:0]  dest;
        logic [31:0] add;
        logic [31:0] rt;
    } exp_t;

    always #5 clk = ~clk;

    ex_pipe dut (
        .clk                 (clk),
        .rst                 (rst),
        .flush               (flush),
        .in_valid            (in_valid),
        .in_ready            (in_ready),
        .alu_funct           (alu_funct),
        .alu_src             (alu_src),
        .sel_reg_dest        (sel_reg_dest),
        .sel_fl_write_enable (sel_fl_write_enable),
        .address_rt          (address_rt),
        .address_rd          (address_rd),
        .data_rs             (data_rs),
        .data_rt             (data_rt),
        .imm                 (imm),
        .next_pc             (next_pc),
        .out_valid           (out_valid),
        .out_ready           (out_ready),
        .out_alu_data        (out_alu_data),
        .out_alu_flags       (out_alu_flags),
        .out_fl_we           (out_fl_we),
        .out_dest            (out_dest),
        .out_add             (out_add),
        .out_data_rt         (out_data_rt)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_op(input logic [5:0] f, input logic src, input logic [1:0] sel,
                            input logic fwe, input logic [4:0] rt_a, input logic [4:0] rd_a,
                            input logic [31:0] rs_d, input logic [31:0] rt_d,
                            input logic [31:0] im, input logic [31:0] pc);
        alu_funct           = f;
        alu_src             = src;
        sel_reg_dest        = sel;
        sel_fl_write_enable = fwe;
        address_rt          = rt_a;
        address_rd          = rd_a;
        data_rs             = rs_d;
        data_rt             = rt_d;
        imm                 = im;
        next_pc             = pc;
    endtask

    function automatic logic [31:0] ref_result(input logic [5:0] f, input logic [31:0] a,
                                               input logic [31:0] b);
        logic [63:0] p;
        case (f)
            6'h20: return a + b;
            6'h22: return a - b;
            6'h24: return a & b;
            6'h25: return a | b;
            6'h26: return a ^ b;
            6'h2A: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            6'h00: return a << b[4:0];
            6'h02: return a >> b[4:0];
            6'h18: begin
                p = {32'd0, a} * {32'd0, b};
                return p[31:0];
            end
            default: return 32'd0;
        endcase
    endfunction

    function automatic exp_t ref_op(input logic [5:0] f, input logic src, input logic [1:0] sel,
                                    input logic fwe, input logic [4:0] rt_a, input logic [4:0] rd_a,
                                    input logic [31:0] rs_d, input logic [31:0] rt_d,
                                    input logic [31:0] im, input logic [31:0] pc);
        exp_t e;
        e.data  = ref_result(f, rs_d, src ? im : rt_d);
        e.flags = {e.data[31], e.data == 32'd0};
        e.fwe   = fwe;
        e.dest  = (sel == 2'd1) ? rd_a : (sel == 2'd2) ? 5'd15 : rt_a;
        e.add   = pc + im;
        e.rt    = rt_d;
        return e;
    endfunction

    task automatic test_reset();
        rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        drive_op(6'h20, 1'b0, 2'd0, 1'b0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 32'd0);
        step();
        step();
        total++;
        if ({out_valid, out_alu_data, out_alu_flags, out_fl_we, out_dest, out_add, out_data_rt} !== '0) begin
            bad++; $display("FAIL reset_outputs: got valid=%0b data=%0h dest=%0h add=%0h want all 0",
                            out_valid, out_alu_data, out_dest, out_add);
        end
        total++;
        if (in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready: got %0b want 0", in_ready); end
        rst = 1'b1;
        #1;
        total++;
        if (in_ready !== 1'b1) begin bad++; $display("FAIL release_in_ready: got %0b want 1", in_ready); end
    endtask

    task automatic test_add_imm();
        out_ready = 1'b1;
        drive_op(6'h20, 1'b1, 2'd1, 1'b1, 5'd3, 5'd7, 32'd5, 32'h1234, 32'hFFFF_FFFB, 32'h100);
        in_valid = 1'b1;
        #1;
        total++;
        if (in_ready !== 1'b1) begin bad++; $display("FAIL add_in_ready: got %0b want 1", in_ready); end
        step();
        in_valid = 1'b0;
        #1;
        total++;
        if ({out_valid, out_alu_data, out_alu_flags} !== {1'b1, 32'd0, 2'b01}) begin
            bad++; $display("FAIL add_result: got v=%0b d=%0h f=%0b want v=1 d=0 f=01",
                            out_valid, out_alu_data, out_alu_flags);
        end
        total++;
        if ({out_fl_we, out_dest, out_add, out_data_rt} !== {1'b1, 5'd7, 32'hFB, 32'h1234}) begin
            bad++; $display("FAIL add_side: got we=%0b dest=%0d add=%0h rt=%0h want 1 7 fb 1234",
                            out_fl_we, out_dest, out_add, out_data_rt);
        end
        drive_op(6'h3F, 1'b0, 2'd0, 1'b0, 5'd1, 5'd2, 32'hDEAD, 32'hBEEF, 32'd0, 32'd0);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        #1;
        total++;
        if ({out_valid, out_alu_data, out_alu_flags} !== {1'b1, 32'd0, 2'b01}) begin
            bad++; $display("FAIL undefined_op: got v=%0b d=%0h f=%0b want v=1 d=0 f=01",
                            out_valid, out_alu_data, out_alu_flags);
        end
        step();
        total++;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL consume: got valid=%0b want 0", out_valid); end
    endtask

    task automatic test_mul();
        int lat;
        out_ready = 1'b1;
        drive_op(6'h18, 1'b0, 2'd0, 1'b0, 5'd4, 5'd0, 32'd7, 32'd6, 32'd0, 32'd0);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        for (int k = 1; k <= 32; k++) begin
            total++;
            if (in_ready !== 1'b0) begin bad++; $display("FAIL mul_busy_ready c%0d: got %0b want 0", k, in_ready); end
            total++;
            if (out_valid !== (k == 32)) begin
                bad++; $display("FAIL mul_valid c%0d: got %0b want %0b", k, out_valid, (k == 32));
            end
            if (k == 32) begin
                total++;
                if (out_alu_data !== 32'd42) begin bad++; $display("FAIL mul_7x6: got %0d want 42", out_alu_data); end
            end
            step();
        end
        total++;
        if ({in_ready, out_valid} !== 2'b10) begin
            bad++; $display("FAIL mul_after: got ready=%0b valid=%0b want 1 0", in_ready, out_valid);
        end
        drive_op(6'h18, 1'b1, 2'd0, 1'b0, 5'd4, 5'd0, 32'hFFFF_FFFF, 32'd0, 32'd2, 32'd0);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 100) begin
            step();
            lat++;
        end
        total++;
        if (lat !== 32) begin bad++; $display("FAIL mul_latency: got %0d want 32", lat); end
        total++;
        if ({out_alu_data, out_alu_flags} !== {32'hFFFF_FFFE, 2'b10}) begin
            bad++; $display("FAIL mul_wrap: got %0h f=%0b want fffffffe f=10", out_alu_data, out_alu_flags);
        end
        step();
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        drive_op(6'h22, 1'b0, 2'd0, 1'b0, 5'd1, 5'd0, 32'd10, 32'd25, 32'd0, 32'd0);
        in_valid = 1'b1;
        step();
        drive_op(6'h2A, 1'b0, 2'd0, 1'b1, 5'd2, 5'd0, 32'hFFFF_FFFD, 32'd2, 32'd0, 32'd0);
        #1;
        total++;
        if ({out_valid, out_alu_data, out_alu_flags, in_ready} !== {1'b1, 32'hFFFF_FFF1, 2'b10, 1'b1}) begin
            bad++; $display("FAIL sub_result: got v=%0b d=%0h f=%0b rdy=%0b want 1 fffffff1 10 1",
                            out_valid, out_alu_data, out_alu_flags, in_ready);
        end
        step();
        drive_op(6'h20, 1'b1, 2'd0, 1'b0, 5'd3, 5'd0, 32'd1, 32'd0, 32'd1, 32'd0);
        out_ready = 1'b0;
        #1;
        total++;
        if ({out_valid, out_alu_data, out_alu_flags, out_dest} !== {1'b1, 32'd1, 2'b00, 5'd2}) begin
            bad++; $display("FAIL slt_result: got v=%0b d=%0h f=%0b dest=%0d want 1 1 00 2",
                            out_valid, out_alu_data, out_alu_flags, out_dest);
        end
        for (int k = 0; k < 3; k++) begin
            total++;
            if ({in_ready, out_valid, out_alu_data, out_fl_we, out_dest} !== {1'b0, 1'b1, 32'd1, 1'b1, 5'd2}) begin
                bad++; $display("FAIL stall_hold c%0d: got rdy=%0b v=%0b d=%0h we=%0b dest=%0d want 0 1 1 1 2",
                                k, in_ready, out_valid, out_alu_data, out_fl_we, out_dest);
            end
            step();
        end
        out_ready = 1'b1;
        #1;
        step();
        in_valid = 1'b0;
        #1;
        total++;
        if ({out_valid, out_alu_data, out_dest} !== {1'b1, 32'd2, 5'd3}) begin
            bad++; $display("FAIL resume: got v=%0b d=%0h dest=%0d want 1 2 3", out_valid, out_alu_data, out_dest);
        end
        step();
    endtask

    task automatic test_dest();
        out_ready = 1'b1;
        drive_op(6'h20, 1'b1, 2'd2, 1'b0, 5'd9, 5'd11, 32'd0, 32'd0, 32'hFFFF_FFF0, 32'h10);
        in_valid = 1'b1;
        step();
        drive_op(6'h25, 1'b0, 2'd3, 1'b0, 5'd9, 5'd11, 32'd0, 32'd0, 32'd0, 32'd0);
        #1;
        total++;
        if ({out_dest, out_add} !== {5'd15, 32'd0}) begin
            bad++; $display("FAIL link_dest: got dest=%0d add=%0h want 15 0", out_dest, out_add);
        end
        step();
        in_valid = 1'b0;
        #1;
        total++;
        if (out_dest !== 5'd9) begin bad++; $display("FAIL reserved_dest: got %0d want 9", out_dest); end
        step();
    endtask

    task automatic test_flush();
        logic seen;
        out_ready = 1'b1;
        drive_op(6'h18, 1'b0, 2'd0, 1'b0, 5'd4, 5'd0, 32'd3, 32'd5, 32'd0, 32'd0);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        repeat (9) step();
        flush = 1'b1;
        #1;
        total++;
        if (in_ready !== 1'b0) begin bad++; $display("FAIL flush_in_ready: got %0b want 0", in_ready); end
        step();
        flush = 1'b0;
        #1;
        total++;
        if ({out_valid, in_ready} !== 2'b01) begin
            bad++; $display("FAIL flush_mul: got v=%0b rdy=%0b want 0 1", out_valid, in_ready);
        end
        seen = 1'b0;
        repeat (40) begin
            step();
            seen |= out_valid;
        end
        total++;
        if (seen !== 1'b0) begin bad++; $display("FAIL flush_late_result: got %0b want 0", seen); end
        out_ready = 1'b0;
        drive_op(6'h20, 1'b0, 2'd0, 1'b0, 5'd1, 5'd0, 32'd1, 32'd1, 32'd0, 32'd0);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        flush = 1'b1;
        step();
        flush = 1'b0;
        #1;
        total++;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_pending: got %0b want 0", out_valid); end
    endtask

    task automatic test_reset_mid_mul();
        logic seen;
        out_ready = 1'b1;
        drive_op(6'h18, 1'b1, 2'd1, 1'b1, 5'd4, 5'd13, 32'd9, 32'h55, 32'd9, 32'h40);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        repeat (5) step();
        rst = 1'b0;
        step();
        total++;
        if ({in_ready, out_valid, out_alu_data, out_alu_flags, out_fl_we, out_dest, out_add, out_data_rt} !== '0) begin
            bad++; $display("FAIL reset_mid_mul: got rdy=%0b v=%0b we=%0b dest=%0d add=%0h rt=%0h want all 0",
                            in_ready, out_valid, out_fl_we, out_dest, out_add, out_data_rt);
        end
        rst = 1'b1;
        #1;
        total++;
        if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_release_ready: got %0b want 1", in_ready); end
        seen = 1'b0;
        repeat (40) begin
            step();
            seen |= out_valid;
        end
        total++;
        if (seen !== 1'b0) begin bad++; $display("FAIL reset_discard: got %0b want 0", seen); end
    endtask

    task automatic test_random();
        exp_t q[$];
        exp_t e;
        exp_t snap;
        logic [5:0] ops [9] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h2A, 6'h00, 6'h02, 6'h3B};
        logic [5:0] f;
        logic have_op = 1'b0;
        logic stall_prev = 1'b0;
        logic acc;
        int n_acc = 0;
        int cyc = 0;
        in_valid = 1'b0;
        while ((n_acc < 80 || q.size() > 0 || have_op) && cyc < 20000) begin
            out_ready = ($urandom_range(0, 3) != 0);
            if (!have_op && n_acc < 80 && $urandom_range(0, 2) != 0) begin
                f = ($urandom_range(0, 9) == 0) ? 6'h18 : ops[$urandom_range(0, 8)];
                drive_op(f, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                         5'($urandom), 5'($urandom), $urandom, $urandom,
                         ($urandom_range(0, 1) != 0) ? $urandom : 32'($signed(8'($urandom))), $urandom);
                in_valid = 1'b1;
                have_op = 1'b1;
            end
            #1;
            if (stall_prev) begin
                total++;
                if ({out_valid, out_alu_data, out_alu_flags, out_fl_we, out_dest, out_add, out_data_rt} !==
                    {1'b1, snap}) begin
                    bad++; $display("FAIL rand_hold cyc%0d: got v=%0b d=%0h want v=1 d=%0h",
                                    cyc, out_valid, out_alu_data, snap.data);
                end
            end
            if (out_valid && out_ready) begin
                total++;
                if (q.size() == 0) begin
                    bad++; $display("FAIL rand_unexpected cyc%0d: got d=%0h want no result", cyc, out_alu_data);
                end else begin
                    e = q.pop_front();
                    if ({out_alu_data, out_alu_flags, out_fl_we, out_dest, out_add, out_data_rt} !== e) begin
                        bad++; $display("FAIL rand_result cyc%0d: got d=%0h f=%0b dest=%0d add=%0h want d=%0h f=%0b dest=%0d add=%0h",
                                        cyc, out_alu_data, out_alu_flags, out_dest, out_add,
                                        e.data, e.flags, e.dest, e.add);
                    end
                end
            end
            acc = in_valid && in_ready;
            if (acc) begin
                q.push_back(ref_op(alu_funct, alu_src, sel_reg_dest, sel_fl_write_enable, address_rt,
                                   address_rd, data_rs, data_rt, imm, next_pc));
                n_acc++;
            end
            stall_prev = out_valid && !out_ready;
            snap = {out_alu_data, out_alu_flags, out_fl_we, out_dest, out_add, out_data_rt};
            step();
            if (acc) begin
                in_valid = 1'b0;
                have_op  = 1'b0;
            end
            cyc++;
        end
        total++;
        if (cyc >= 20000) begin
            bad++; $display("FAIL rand_timeout: got accepted=%0d pending=%0d want 80 0", n_acc, q.size());
        end
    endtask

    initial begin
        test_reset();
        test_add_imm();
        test_mul();
        test_back_to_back();
        test_dest();
        test_flush();
        test_reset_mid_mul();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ex_pipe.md
EX_PIPE -- requirements
Module: ex_pipe

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, meaning operand, immediate and result width.
REQ-002 The block SHALL have parameter ADDR_W, default 5, meaning register address width.
REQ-003 The block SHALL have parameter PC_W, default 32, meaning program counter width.
REQ-004 The block SHALL have parameter LINK_REG, default 15, meaning the destination register for link writes.
REQ-005 The block SHALL use one clock; reset is synchronous and active-low.
REQ-006 Ports SHALL be, in this order:
- clk  in  1  clock.
- rst  in  1  synchronous active-low reset.
- flush  in  1  synchronous pipeline flush.
- in_valid  in  1  ID/EX operation valid.
- in_ready  out  1  stage can accept an operation.
- alu_funct  in  6  operation code.
- alu_src  in  1  selects op2: 0 = data_rt, 1 = imm.
- sel_reg_dest  in  2  destination: 0 = address_rt, 1 = address_rd, 2 = LINK_REG, 3 = reserved (treated as 0).
- sel_fl_write_enable  in  1  flag write request.
- address_rt, address_rd  in  ADDR_W  register addresses.
- data_rs, data_rt, imm  in  DATA_W  operands and sign-extended immediate.
- next_pc  in  PC_W  PC+1 of the operation.
- out_valid  out  1  result valid.
- out_ready  in  1  EX/MEM accepts the result.
- out_alu_data  out  DATA_W  result.
- out_alu_flags  out  2  bit0 = zero, bit1 = negative.
- out_fl_we  out  1  registered sel_fl_write_enable.
- out_dest  out  ADDR_W  selected destination register.
- out_add  out  PC_W  branch target, next_pc + imm, low PC_W bits.
- out_data_rt  out  DATA_W  store data.

Function
REQ-007 An operation SHALL be accepted in any cycle where in_valid && in_ready.
REQ-008 Opcodes SHALL be: ADD 0x20, SUB 0x22, AND 0x24, OR 0x25, XOR 0x26, SLT 0x2A (signed, result 0/1), SLL 0x00, SRL 0x02, MUL 0x18. Shifts use op2[log2(DATA_W)-1:0]. MUL keeps the low DATA_W bits of the unsigned product.
REQ-009 Undefined opcodes SHALL produce result 0 and complete with latency 1.
REQ-010 Arithmetic SHALL wrap modulo 2^DATA_W; no overflow flag.
REQ-011 The flags SHALL be computed from the final result: zero = (result == 0), negative = result[DATA_W-1].
REQ-012 The FSM SHALL have states IDLE and MUL. IDLE goes to MUL on accepting opcode 0x18. MUL returns to IDLE after exactly DATA_W iteration cycles, loading the output register on the last cycle.
REQ-013 Non-MUL operations SHALL have latency 1: out_valid rises the cycle after acceptance. MUL SHALL have latency DATA_W.
REQ-014 In state IDLE, in_ready SHALL equal !out_valid || out_ready.
REQ-015 In state MUL, in_ready SHALL be 0.
REQ-016 When flush = 1, in_ready SHALL be 0.
REQ-017 While out_valid && !out_ready, all out_* registers SHALL hold their values.
REQ-018 Consuming a result and accepting a new operation in the same cycle SHALL be supported with no bubble.
REQ-019 out_dest, out_add, out_data_rt and out_fl_we SHALL be captured at acceptance and presented with the result.
REQ-020 Flush SHALL clear out_valid, abort any MUL and return the FSM to IDLE on the next edge. Flush SHALL take priority over acceptance and completion.

Reset
REQ-021 When rst = 0 at a clock edge, the FSM SHALL go to IDLE, out_valid SHALL be 0 and all other outputs SHALL be 0.
REQ-022 Reset SHALL take priority over flush.
REQ-023 Reset during MUL SHALL discard the operation; in_ready SHALL be 1 in the first cycle after reset is released.

Structure
REQ-024 The opcode constants, the flag bit indices and the sel_reg_dest encodings SHALL live in the shared lapido_defs package.
REQ-025 The iterative shift-add multiplier SHALL be a sub-module mul_iter with a start/done handshake and a DATA_W-cycle counter.
REQ-026 The single-cycle ALU and the destination mux SHALL be inline in ex_pipe.

Verification
REQ-027 ADD with data_rs=5, imm=-5, alu_src=1 -> next cycle out_valid=1, out_alu_data=0, out_alu_flags=2'b01.
REQ-028 MUL with 7 x 6 -> in_ready=0 for 32 cycles; out_alu_data=42 appears exactly 32 cycles after acceptance; MUL 0xFFFFFFFF x 2 -> 0xFFFFFFFE.
REQ-029 Back-to-back SUB then SLT with out_ready=1 -> results on consecutive cycles; then out_ready=0 for 3 cycles -> outputs stable and in_ready=0.
REQ-030 sel_reg_dest=2 with next_pc=0x10, imm=0xFFFFFFF0 -> out_dest=15, out_add=0x0.
REQ-031 Flush asserted on MUL cycle 10 -> out_valid stays 0 and in_ready=1 in the next cycle; rst=0 mid-MUL -> all outputs 0.
